aes_req_sched: RTL and testbench

- Round-robin scheduler that shares one aes_top encryptor between NREQ requesters.
- Per request: accepts key and plaintext, issues a single start pulse to aes_top, and waits for done or a watchdog timeout.
- Returns ciphertext tagged with the requester ID over a valid/ready response port.
- Tracks consecutive fault_flag reports and locks the engine out after FAULT_LIMIT of them. Sits between the host-side request fabric and aes_top.

---
 rtl/aes_req_sched.sv | 168 ++++++++++++++++
 tb/tb_aes_req_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_sched.sv
// aes_req_sched: round-robin front end that shares one aes_top between
// NREQ requesters. One request is outstanding at a time. Each response
// carries the requester ID and is returned over a valid/ready port. A
// watchdog abandons requests that never complete. Consecutive faulted
// results lock the engine out until clear_lock.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for aes_busy low and any req_valid; grants in-cycle
// ISSUE  | aes_start pulse for one cycle, watchdog loaded
// WAIT   | waiting for aes_done or the watchdog terminal count
// RESP   | response held on rsp_* until rsp_ready
// LOCKED | too many consecutive faults; only clear_lock leaves
module aes_req_sched #(
    parameter int NREQ           = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FAULT_LIMIT    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*128-1:0]  req_key,
    input  logic [NREQ*128-1:0]  req_pt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [127:0]         rsp_data,
    output logic                 rsp_fault,
    output logic                 rsp_timeout,
    output logic                 aes_start,
    output logic [127:0]         aes_key,
    output logic [127:0]         aes_plaintext,
    input  logic                 aes_busy,
    input  logic                 aes_done,
    input  logic [127:0]         aes_ciphertext,
    input  logic                 aes_fault,
    output logic                 lockout,
    input  logic                 clear_lock
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;

    localparam int SW   = ID_W + 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam int FC_W = $clog2(FAULT_LIMIT + 1);

    // The ISSUE cycle counts as the first watchdog cycle, so WAIT starts
    // two short of the limit and times out on reaching zero.
    localparam logic [WD_W-1:0] WD_LOAD   = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [FC_W-1:0] FC_MAX    = FC_W'(FAULT_LIMIT);
    localparam logic [NREQ-1:0] REQ_ONE   = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NREQ - 1);

    logic [2:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [WD_W-1:0] wdog;
    logic [FC_W-1:0] fault_cnt;
    logic [FC_W-1:0] fc_next;
    logic [SW-1:0]   scan_sum;
    logic [ID_W-1:0] winner;
    logic            grant_any;
    logic            grant_fire;

    // Scan requesters upward from the round-robin pointer, wrapping at NREQ.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        scan_sum  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + SW'(k);
            if (scan_sum >= SW'(NREQ))
                scan_sum = scan_sum - SW'(NREQ);
            if (!grant_any && req_valid[scan_sum[ID_W-1:0]]) begin
                grant_any = 1'b1;
                winner    = scan_sum[ID_W-1:0];
            end
        end
    end

    assign grant_fire = (state == ST_IDLE) && !aes_busy && grant_any;

    // Accept strobe is combinational; it is held low while reset is applied
    // so no requester sees a phantom accept.
    assign req_ready = (grant_fire && rst_n) ? (REQ_ONE << winner) : '0;

    assign rsp_valid = (state == ST_RESP);
    assign aes_start = (state == ST_ISSUE);
    assign lockout   = (state == ST_LOCKED);
    assign rsp_id    = id_q;

    // Fault counter value after the current response is accepted.
    always_comb begin
        fc_next = fault_cnt;
        if (rsp_fault)
            fc_next = (fault_cnt == FC_MAX) ? FC_MAX : fault_cnt + FC_W'(1);
        else if (!rsp_timeout)
            fc_next = '0;
    end

    // Sequencing FSM with request capture, watchdog and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            id_q          <= '0;
            wdog          <= '0;
            fault_cnt     <= '0;
            aes_key       <= '0;
            aes_plaintext <= '0;
            rsp_data      <= '0;
            rsp_fault     <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A late aes_done after a timeout lands here and is dropped.
                    if (grant_fire) begin
                        aes_key       <= req_key[128*winner +: 128];
                        aes_plaintext <= req_pt[128*winner +: 128];
                        id_q          <= winner;
                        rr_ptr        <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wdog  <= WD_LOAD;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (aes_done) begin
                        rsp_data    <= aes_fault ? '0 : aes_ciphertext;
                        rsp_fault   <= aes_fault;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else if (wdog == '0) begin
                        rsp_data    <= '0;
                        rsp_fault   <= 1'b0;
                        rsp_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        wdog <= wdog - WD_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        fault_cnt <= fc_next;
                        state     <= (fc_next == FC_MAX) ? ST_LOCKED : ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (clear_lock) begin
                        fault_cnt <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_sched.sv
// Scoreboard bench for aes_req_sched with a behavioural aes_top stand-in.
module tb_aes_req_sched;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int TO   = 16;
    localparam int FL   = 3;

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*128-1:0] req_key;
    logic [NREQ*128-1:0] req_pt;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [127:0]        rsp_data;
    logic                rsp_fault;
    logic                rsp_timeout;
    logic                aes_start;
    logic [127:0]        aes_key;
    logic [127:0]        aes_plaintext;
    logic                aes_busy;
    logic                aes_done;
    logic [127:0]        aes_ciphertext;
    logic                aes_fault;
    logic                lockout;
    logic                clear_lock;

    aes_req_sched #(
        .NREQ(NREQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TO), .FAULT_LIMIT(FL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_pt(req_pt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_fault(rsp_fault), .rsp_timeout(rsp_timeout),
        .aes_start(aes_start), .aes_key(aes_key), .aes_plaintext(aes_plaintext),
        .aes_busy(aes_busy), .aes_done(aes_done), .aes_ciphertext(aes_ciphertext),
        .aes_fault(aes_fault), .lockout(lockout), .clear_lock(clear_lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [127:0]    data;
        logic            f;
        logic            t;
    } exp_t;

    exp_t rq[$];
    int   gq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // engine stand-in control and timestamps
    int           eng_mode = 0;   // 0 clean, 1 fault, 2 never done
    int           eng_lat  = 1;
    int           eng_hang = 20;
    int           rem      = 0;
    logic [127:0] eng_ct   = '0;
    logic         eng_nb, eng_nd, eng_nf;
    int           start_cyc = 0, done_cyc = 0, grant_cyc = 0, rise_cyc = 0;
    logic         prev_v = 1'b0;

    // reference state
    int m_ptr = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_K && p == FIPS_P)
            return FIPS_C;
        return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    function automatic int predict(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++)
            if (mask[(m_ptr + k) % NREQ])
                return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // behavioural aes_top: busy after start, done after eng_lat cycles
    initial begin
        aes_busy = 1'b0; aes_done = 1'b0; aes_fault = 1'b0; aes_ciphertext = '0;
        forever begin
            @(negedge clk);
            eng_nb = 1'b0; eng_nd = 1'b0; eng_nf = 1'b0;
            if (!rst_n) begin
                rem = 0;
            end else begin
                if (aes_start) begin
                    rem       = (eng_mode == 2) ? eng_hang : eng_lat;
                    eng_ct    = aes_ref(aes_key, aes_plaintext);
                    start_cyc = cyc;
                end
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        if (eng_mode != 2) begin
                            eng_nd   = 1'b1;
                            eng_nf   = (eng_mode == 1);
                            done_cyc = cyc + 1;
                        end
                    end else begin
                        eng_nb = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1;
            aes_busy       = eng_nb;
            aes_done       = eng_nd;
            aes_fault      = eng_nf;
            aes_ciphertext = eng_nd ? eng_ct : '0;
        end
    end

    // monitor: pops expected grants and responses as the DUT presents them
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (req_ready != '0) begin
                grant_cyc = cyc;
                chk("grant_busy", aes_busy, 0);
                if (gq.size() == 0)
                    chk("grant_unexpected", req_ready, 0);
                else
                    chk("grant_id", req_ready, 128'(1) << gq.pop_front());
            end
            if (rsp_valid && !prev_v)
                rise_cyc = cyc;
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_fault", rsp_fault, e.f);
                    chk("rsp_timeout", rsp_timeout, e.t);
                end
            end
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_id, rsp_fault, rsp_timeout, aes_start, lockout}, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_aes_key"}, aes_key, 0);
        chk({tag, "_aes_pt"}, aes_plaintext, 0);
    endtask

    task automatic locked_phase();
        bit bad = 1'b0;
        @(posedge clk); #1;
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0 || rsp_valid || !lockout) bad = 1'b1;
        end
        chk("locked_block", bad, 0);
        @(posedge clk); #1;
        req_valid  = '0;
        clear_lock = 1'b1;
        @(posedge clk); #1;
        clear_lock = 1'b0;
        chk("lock_clear", lockout, 0);
        m_cnt = 0;
    endtask

    task automatic run_txn(input logic [NREQ-1:0] mask, input int mode, input int lat,
                           input int stall, input bit keep);
        int          w;
        exp_t        e;
        bit          got;
        bit          bad;
        logic [131:0] snap;
        if (!keep)
            for (int i = 0; i < NREQ; i++) begin
                req_key[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
                req_pt[128*i +: 128]  = {$urandom, $urandom, $urandom, $urandom};
            end
        w      = predict(mask);
        m_ptr  = (w + 1) % NREQ;
        e.id   = ID_W'(w);
        e.f    = (mode == 1);
        e.t    = (mode == 2);
        e.data = (mode == 0) ? aes_ref(req_key[128*w +: 128], req_pt[128*w +: 128]) : '0;
        gq.push_back(w);
        rq.push_back(e);
        eng_mode = mode;
        eng_lat  = lat;
        eng_hang = TO + 2 + int'($urandom_range(0, 4));

        req_valid = mask;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1'b1;
        end
        chk("grant_seen", got, 1);
        @(posedge clk); #1;
        req_valid = '0;

        got = 1'b0;
        for (int c = 0; c < TO + 40 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        chk("rsp_seen", got, 1);

        snap = {rsp_id, rsp_data, rsp_fault, rsp_timeout};
        bad  = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if ({rsp_id, rsp_data, rsp_fault, rsp_timeout} !== snap || !rsp_valid ||
                req_ready != '0 || aes_start)
                bad = 1'b1;
        end
        if (stall > 0)
            chk("stall_stable", bad, 0);

        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);

        if (got) begin
            chk("start_lat", start_cyc - grant_cyc, 1);
            if (mode == 2)
                chk("timeout_lat", rise_cyc - start_cyc, TO);
            else
                chk("done_lat", rise_cyc - done_cyc, 1);
        end

        if (mode == 1)
            m_cnt = (m_cnt < FL) ? m_cnt + 1 : FL;
        else if (mode == 0)
            m_cnt = 0;
        chk("lockout", lockout, m_cnt == FL);
        if (m_cnt == FL)
            locked_phase();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int  w;
        bit  got;
        rst_n      = 1'b0;
        req_valid  = '1;
        req_key    = '0;
        req_pt     = '0;
        rsp_ready  = 1'b0;
        clear_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk); #1;

        // round robin, all requesters
        for (int i = 0; i < 8; i++)
            run_txn('1, 0, int'($urandom_range(1, 8)), int'($urandom_range(0, 2)), 1'b0);
        // move pointer to 3, then only 2 and 0 contend
        run_txn(4'b0100, 0, 2, 0, 1'b0);
        for (int i = 0; i < 3; i++)
            run_txn(4'b0101, 0, int'($urandom_range(1, 6)), 0, 1'b0);

        // FIPS-197 vector on requester 1
        req_key[128 +: 128] = FIPS_K;
        req_pt[128 +: 128]  = FIPS_P;
        run_txn(4'b0010, 0, 5, 0, 1'b1);

        // backpressure
        run_txn(4'(int'($urandom_range(1, 15))), 0, 4, 20, 1'b0);

        // timeout then an immediate follow-up that must wait for aes_busy
        run_txn('1, 2, 0, 0, 1'b0);
        run_txn('1, 0, 3, 0, 1'b0);

        // three consecutive faults lock the engine, then service resumes
        for (int i = 0; i < 3; i++)
            run_txn(4'(int'($urandom_range(1, 15))), 1, int'($urandom_range(1, 8)), 0, 1'b0);
        run_txn('1, 0, 2, 0, 1'b0);

        // a clean result between faults restarts the count
        run_txn('1, 1, 3, 0, 1'b0);
        run_txn('1, 1, 3, 0, 1'b0);
        run_txn('1, 0, 3, 0, 1'b0);
        run_txn('1, 1, 3, 0, 1'b0);
        run_txn('1, 1, 3, 0, 1'b0);
        run_txn('1, 0, 3, 0, 1'b0);

        // randomized mix
        for (int i = 0; i < 25; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            run_txn(4'(int'($urandom_range(1, 15))), (r < 70) ? 0 : (r < 85) ? 1 : 2,
                    int'($urandom_range(1, 12)), int'($urandom_range(0, 3)), 1'b0);
        end

        // async reset while waiting on the engine
        w = predict('1);
        gq.push_back(w);
        eng_mode = 2;
        eng_hang = 200;
        req_valid = '1;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1'b1;
        end
        chk("rst_grant_seen", got, 1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #3;
        req_valid = '1;
        rst_n     = 1'b0;
        #1;
        chk_reset("reset_async");
        m_ptr = 0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        run_txn('1, 0, 4, 0, 1'b0);

        repeat (5) @(posedge clk);
        chk("grant_q_empty", gq.size(), 0);
        chk("rsp_q_empty", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
